// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter for the write port of a command FIFO.
// Requester 0 is CPU bus-cycle capture, requester 1 is the DMA/refresh engine.
// Grants are bounded in burst length, writes are gated on fifo_full, and data is
// forwarded combinationally from the owner to the FIFO write port.
module fifo_wr_arbiter #(
  parameter int unsigned DWIDTH    = 40,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DWIDTH-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DWIDTH-1:0] data1,
  output logic              ack1,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DWIDTH-1:0] fifo_wr_data,
  output logic [1:0]        owner
);

  localparam int unsigned   BW   = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [BW-1:0] beats, beats_nx;
  logic [BW-1:0] beats_inc;
  logic          own_req;
  logic          oth_req;

  // State, last-served owner and burst counter; reset makes req0 win the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      beats <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      beats <= beats_nx;
    end
  end

  // Arbitration, release decisions and combinational write-port muxing
  always_comb begin
    state_nx     = state;
    last_nx      = last;
    beats_nx     = beats;
    beats_inc    = beats;
    own_req      = 1'b0;
    oth_req      = 1'b0;
    fifo_wr      = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    fifo_wr_data = '0;
    owner        = 2'b00;

    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nx = last ? GNT0 : GNT1;
        end else if (req0) begin
          state_nx = GNT0;
        end else if (req1) begin
          state_nx = GNT1;
        end
      end

      GNT0, GNT1: begin
        own_req      = (state == GNT0) ? req0 : req1;
        oth_req      = (state == GNT0) ? req1 : req0;
        // An in-flight beat during reset is dropped rather than written
        fifo_wr      = own_req & ~fifo_full & ~reset;
        ack0         = fifo_wr & (state == GNT0);
        ack1         = fifo_wr & (state == GNT1);
        fifo_wr_data = (state == GNT0) ? data0 : data1;
        owner        = (state == GNT0) ? 2'b01 : 2'b10;
        // Counter saturates so a lone owner can keep streaming past the limit
        beats_inc    = (beats == BMAX) ? beats : beats + BW'(1);

        if (!own_req || (fifo_wr && (beats_inc == BMAX) && oth_req)) begin
          last_nx  = (state == GNT1);
          beats_nx = '0;
          if (oth_req) begin
            state_nx = (state == GNT0) ? GNT1 : GNT0;
          end else begin
            state_nx = IDLE;
          end
        end else if (fifo_wr) begin
          beats_nx = beats_inc;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
